// File: rtl/icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : icache_refill_ctrl
//  Description : Miss-handling sequencer for a direct-mapped instruction cache
//                (8 lines x 128 bits). On a lookup miss it stalls fetch,
//                reads the four words of the line from memory one beat at a
//                time, writes the assembled line into the cache, and then
//                re-runs the lookup.
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_refill_ctrl #(
    parameter int ADDR_W = 32,
    parameter int BEATS  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cpu_req,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic                cache_hit,
    output logic                stall,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_ack,
    input  logic [31:0]         mem_rdata,
    output logic                line_we,
    output logic [ADDR_W-1:0]   line_addr,
    output logic [127:0]        line_data,
    output logic [CNT_W-1:0]    miss_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_REFILL = 2'd2,
        ST_WRITE  = 2'd3
    } state_t;

    localparam logic [1:0] c_LAST_BEAT = 2'(BEATS - 1);

    state_t              r_state;
    logic [ADDR_W-1:4]   r_addr_q;
    logic [1:0]          r_beat;
    logic                r_mem_req;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_line_we;
    logic [ADDR_W-1:0]   r_line_addr;
    logic [127:0]        r_line_data;
    logic [CNT_W-1:0]    r_miss_count;

    // Byte offset within the line never matters: refills are whole lines.
    logic w_unused_offset;
    assign w_unused_offset = ^cpu_addr[3:0];

    // Stall follows the hit flag during lookup so hits cost no extra cycle;
    // refill and write always hold fetch.
    logic w_stall;
    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            ST_LOOKUP: w_stall = ~cache_hit;
            ST_REFILL: w_stall = 1'b1;
            ST_WRITE:  w_stall = 1'b1;
            default:   w_stall = 1'b0;
        endcase
    end

    // Main sequencer: lookup, beat-by-beat refill, line write, re-lookup.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_addr_q     <= '0;
            r_beat       <= 2'd0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_line_we    <= 1'b0;
            r_line_addr  <= '0;
            r_line_data  <= '0;
            r_miss_count <= '0;
        end else begin
            r_line_we <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cpu_req) begin
                        r_addr_q <= cpu_addr[ADDR_W-1:4];
                        r_state  <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (cache_hit) begin
                        if (cpu_req) begin
                            r_addr_q <= cpu_addr[ADDR_W-1:4];
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_state    <= ST_REFILL;
                        r_beat     <= 2'd0;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= {r_addr_q, 4'b0000};
                        if (r_miss_count != {CNT_W{1'b1}}) begin
                            r_miss_count <= r_miss_count + 1'b1;
                        end
                    end
                end
                ST_REFILL: begin
                    // Request and address hold steady across any number of
                    // wait cycles; only an ack advances the beat.
                    if (mem_ack) begin
                        r_line_data[{r_beat, 5'b00000} +: 32] <= mem_rdata;
                        if (r_beat == c_LAST_BEAT) begin
                            r_mem_req   <= 1'b0;
                            r_line_we   <= 1'b1;
                            r_line_addr <= {r_addr_q, 4'b0000};
                            r_beat      <= 2'd0;
                            r_state     <= ST_WRITE;
                        end else begin
                            r_beat     <= r_beat + 2'd1;
                            r_mem_addr <= {r_addr_q, r_beat + 2'd1, 2'b00};
                        end
                    end
                end
                ST_WRITE: begin
                    // Re-lookup the same address so the fetch completes as a hit.
                    r_state <= ST_LOOKUP;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign stall      = w_stall;
    assign mem_req    = r_mem_req;
    assign mem_addr   = r_mem_addr;
    assign line_we    = r_line_we;
    assign line_addr  = r_line_addr;
    assign line_data  = r_line_data;
    assign miss_count = r_miss_count;

endmodule
`default_nettype wire

// File: tb/tb_icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icache_refill_ctrl
//  Description : Directed bench for icache_refill_ctrl. A second instance with
//                a 2-bit miss counter shares all inputs to exercise saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_refill_ctrl;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req;
    logic [31:0]   cpu_addr;
    logic          cache_hit;
    logic          mem_ack;
    logic [31:0]   mem_rdata;

    logic          stall, mem_req, line_we;
    logic [31:0]   mem_addr, line_addr;
    logic [127:0]  line_data;
    logic [15:0]   miss_count;

    logic          s_stall, s_mem_req, s_line_we;
    logic [31:0]   s_mem_addr, s_line_addr;
    logic [127:0]  s_line_data;
    logic [1:0]    s_miss_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    icache_refill_ctrl dut (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
        .cache_hit(cache_hit), .stall(stall), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .line_we(line_we), .line_addr(line_addr), .line_data(line_data),
        .miss_count(miss_count)
    );

    icache_refill_ctrl #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
        .cache_hit(cache_hit), .stall(s_stall), .mem_req(s_mem_req),
        .mem_addr(s_mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .line_we(s_line_we), .line_addr(s_line_addr), .line_data(s_line_data),
        .miss_count(s_miss_count)
    );

    typedef struct {
        logic         req;
        logic [31:0]  addr;
        logic         hit;
        logic         ack;
        logic [31:0]  rdata;
        logic         e_stall;
        logic         e_mreq;
        logic [31:0]  e_maddr;
        logic         e_we;
        logic [31:0]  e_laddr;
        logic [127:0] e_data;
        logic [15:0]  e_cnt;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One complete miss: request, lookup miss, four beats with 'gap' idle
    // cycles before each ack, line write, re-lookup hit, back to idle.
    task automatic do_miss(input logic [31:0] a, input logic [31:0] d0, input int gap,
                           input logic [15:0] ecnt, input logic [1:0] esat);
        logic [31:0] base;
        base = {a[31:4], 4'b0000};
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = a; cache_hit = 1'b0; mem_ack = 1'b0;
        #1 chk("miss_idle_stall", stall, 1'b0);
        @(negedge clk);
        #1 chk("miss_lookup_stall", stall, 1'b1);
        chk("miss_lookup_mreq", mem_req, 1'b0);
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                cpu_addr = 32'hDEAD_BEEF; cpu_req = 1'b1; mem_ack = 1'b0;
                #1 chk("gap_stall", stall, 1'b1);
                chk("gap_mreq", mem_req, 1'b1);
                chk("gap_maddr", mem_addr, base + 32'(4 * b));
                chk("gap_we", line_we, 1'b0);
            end
            @(negedge clk);
            mem_ack = 1'b1; mem_rdata = d0 + 32'(b);
            #1 chk("beat_stall", stall, 1'b1);
            chk("beat_mreq", mem_req, 1'b1);
            chk("beat_maddr", mem_addr, base + 32'(4 * b));
            chk("beat_cnt", miss_count, ecnt);
        end
        @(negedge clk);
        mem_ack = 1'b0; cpu_addr = a; cpu_req = 1'b0;
        #1 chk("write_we", line_we, 1'b1);
        chk("write_stall", stall, 1'b1);
        chk("write_mreq", mem_req, 1'b0);
        chk("write_laddr", line_addr, base);
        chk("write_data", line_data, {d0 + 32'd3, d0 + 32'd2, d0 + 32'd1, d0});
        chk("write_cnt", miss_count, ecnt);
        chk("sat_cnt", s_miss_count, esat);
        @(negedge clk);
        cache_hit = 1'b1;
        #1 chk("relookup_stall", stall, 1'b0);
        chk("relookup_we", line_we, 1'b0);
        chk("hold_data", line_data, {d0 + 32'd3, d0 + 32'd2, d0 + 32'd1, d0});
    endtask

    initial begin
        vt[0]  = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,    1'b0, 32'h0,    128'h0, 16'd0};
        vt[1]  = '{1'b1, 32'h40,   1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,    1'b0, 32'h0,    128'h0, 16'd0};
        vt[2]  = '{1'b0, 32'h40,   1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,    1'b0, 32'h0,    128'h0, 16'd0};
        vt[3]  = '{1'b1, 32'h1234, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,    1'b0, 32'h0,    128'h0, 16'd0};
        vt[4]  = '{1'b1, 32'h1234, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,    1'b0, 32'h0,    128'h0, 16'd0};
        vt[5]  = '{1'b1, 32'h1234, 1'b0, 1'b1, 32'hA0, 1'b1, 1'b1, 32'h1230, 1'b0, 32'h0,    128'h0, 16'd1};
        vt[6]  = '{1'b1, 32'h1234, 1'b0, 1'b1, 32'hA1, 1'b1, 1'b1, 32'h1234, 1'b0, 32'h0,
                   128'h000000A0, 16'd1};
        vt[7]  = '{1'b1, 32'h1234, 1'b0, 1'b1, 32'hA2, 1'b1, 1'b1, 32'h1238, 1'b0, 32'h0,
                   128'h000000A1_000000A0, 16'd1};
        vt[8]  = '{1'b1, 32'h1234, 1'b0, 1'b1, 32'hA3, 1'b1, 1'b1, 32'h123C, 1'b0, 32'h0,
                   128'h000000A2_000000A1_000000A0, 16'd1};
        vt[9]  = '{1'b1, 32'h1234, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h123C, 1'b1, 32'h1230,
                   128'h000000A3_000000A2_000000A1_000000A0, 16'd1};
        vt[10] = '{1'b0, 32'h1234, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 32'h123C, 1'b0, 32'h1230,
                   128'h000000A3_000000A2_000000A1_000000A0, 16'd1};
        vt[11] = '{1'b0, 32'h0,    1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h123C, 1'b0, 32'h1230,
                   128'h000000A3_000000A2_000000A1_000000A0, 16'd1};

        reset = 1'b1; cpu_req = 1'b0; cpu_addr = '0; cache_hit = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state, hit at 0x40, then a miss at 0x1234 with back-to-back acks.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            cpu_req = vt[i].req; cpu_addr = vt[i].addr; cache_hit = vt[i].hit;
            mem_ack = vt[i].ack; mem_rdata = vt[i].rdata;
            #1;
            chk($sformatf("v%0d_stall", i), stall, vt[i].e_stall);
            chk($sformatf("v%0d_mreq", i), mem_req, vt[i].e_mreq);
            chk($sformatf("v%0d_maddr", i), mem_addr, vt[i].e_maddr);
            chk($sformatf("v%0d_we", i), line_we, vt[i].e_we);
            chk($sformatf("v%0d_laddr", i), line_addr, vt[i].e_laddr);
            chk($sformatf("v%0d_data", i), line_data, vt[i].e_data);
            chk($sformatf("v%0d_cnt", i), miss_count, vt[i].e_cnt);
        end

        // Back-to-back hits at 0x00, 0x04, 0x08.
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = 32'h0; cache_hit = 1'b0; mem_ack = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            cpu_req = (i < 3); cpu_addr = 32'(4 * i); cache_hit = 1'b1;
            #1 chk("b2b_stall", stall, 1'b0);
            chk("b2b_mreq", mem_req, 1'b0);
        end
        @(negedge clk);
        cpu_req = 1'b0; cache_hit = 1'b0;
        #1 chk("b2b_idle_stall", stall, 1'b0);
        chk("b2b_cnt", miss_count, 16'd1);

        // Gapped acks, then two quick misses that push the narrow counter to saturation.
        do_miss(32'h0000_2008, 32'h0000_00B0, 3, 16'd2, 2'd2);
        do_miss(32'h0000_4010, 32'h0000_00D0, 0, 16'd3, 2'd3);
        do_miss(32'h0000_5020, 32'h0000_00E0, 1, 16'd4, 2'd3);

        // Reset in the middle of a refill, after beat 1 ack, then stray acks.
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = 32'h3000; cache_hit = 1'b0;
        @(negedge clk);
        cpu_req = 1'b0;
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'hC0;
        @(negedge clk);
        mem_rdata = 32'hC1;
        #1 chk("pre_rst_cnt", miss_count, 16'd5);
        @(negedge clk);
        mem_ack = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1 chk("rst_mreq", mem_req, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_we", line_we, 1'b0);
        chk("rst_maddr", mem_addr, 32'h0);
        chk("rst_data", line_data, 128'h0);
        chk("rst_cnt", miss_count, 16'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
            #1 chk("stray_mreq", mem_req, 1'b0);
            chk("stray_we", line_we, 1'b0);
            chk("stray_stall", stall, 1'b0);
            chk("stray_data", line_data, 128'h0);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        #1 chk("stray_final_data", line_data, 128'h0);
        chk("stray_final_cnt", miss_count, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
- Miss-handling sequencer for the direct-mapped instruction cache: 8 lines × 128 bits, 25-bit tag, valid bit.
- Sits between the fetch stage, the cache and the instruction memory.
- On a fetch request it waits for the cache lookup result. On a miss it stalls fetch, reads the 4 words of the line from memory one beat at a time, and assembles them into a 128-bit line.
- It then writes the line into the cache and re-runs the lookup so the fetch completes as a hit.

Parameters:
- ADDR_W, 32, byte address width. Only 32 is supported; the tag is [31:7], the index [6:4] and the word select [3:2].
- BEATS, 4, words per line. Fixed at 4 to match the 128-bit line.
- CNT_W, 16, width of the miss counter.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  fetch request valid.
- cpu_addr  in  32  fetch byte address.
- cache_hit  in  1  hit flag from the cache; valid in the cycle after the address was presented.
- stall  out  1  holds fetch; the PC and cpu_addr must stay stable while it is 1.
- mem_req  out  1  memory read request for the current beat.
- mem_addr  out  32  word address of the current beat.
- mem_ack  in  1  beat data valid.
- mem_rdata  in  32  beat data.
- line_we  out  1  one-cycle line write strobe to the cache.
- line_addr  out  32  line-aligned address for the cache write; its tag and index are used.
- line_data  out  128  assembled line; word k sits at bits [32k+31:32k].
- miss_count  out  CNT_W  saturating miss counter.

Behaviour:
- Reset values: state IDLE, stall 0, mem_req 0, mem_addr 0, line_we 0, line_addr 0, line_data 0, miss_count 0. The beat counter and addr_q are also cleared.
- Reset has priority over every other event.
- Reset mid-REFILL abandons the refill: mem_req is 0 in the next cycle, no line_we, no count change. Late mem_ack pulses after reset are ignored.
- States: IDLE, LOOKUP, REFILL, WRITE.
- IDLE:
  - cpu_req=1 → latch addr_q=cpu_addr, go to LOOKUP.
  - cpu_req=0 → stay in IDLE.
  - stall=0.
- LOOKUP: sample cache_hit.
  - Hit, cpu_req=1 → latch the new cpu_addr and stay in LOOKUP (back-to-back hits, one per cycle).
  - Hit, cpu_req=0 → go to IDLE.
  - Miss → go to REFILL, set beat=0, miss_count+1 (holds at all-ones).
  - stall = ~cache_hit (combinational in this state).
- REFILL:
  - stall=1, mem_req=1.
  - mem_addr = {addr_q[31:4], beat[1:0], 2'b00}.
  - On mem_ack: line_data word[beat] = mem_rdata, then beat+1.
  - The ack on beat 3 → go to WRITE.
  - mem_req stays high continuously until that last ack; the number of wait cycles between acks is unbounded.
- WRITE:
  - stall=1, line_we=1 for exactly one cycle.
  - line_addr = {addr_q[31:4], 4'b0}.
  - Next state is LOOKUP with addr_q unchanged (re-lookup).
  - A second miss there starts a new refill and counts again.
- Ignored inputs:
  - mem_ack outside REFILL.
  - cpu_addr changes while stall=1; addr_q is used throughout.
  - cpu_req in REFILL and WRITE.
- Hold behaviour:
  - line_data holds after WRITE until overwritten by the next refill.
  - Words are written only on ack.
- Latency:
  - Hit: 1 cycle after request.
  - Miss: 1 (lookup) + N_ack cycles (≥4) + 1 (write) + 1 (re-lookup) before stall drops.
  - Minimum miss penalty is 7 cycles from request.
- The miss counter wraps never; it saturates at 2^CNT_W−1.

Test Plan:
- Reset, then cpu_req with cpu_addr=0x0000_0040 and cache_hit=1 → stall=0 in LOOKUP, miss_count=0, mem_req never asserted.
- Miss at 0x0000_1234 with mem_ack every cycle and rdata 0xA0,0xA1,0xA2,0xA3:
  - mem_addr sequence is 0x1230, 0x1234, 0x1238, 0x123C.
  - line_we is high one cycle with line_addr=0x0000_1230 and line_data=0x000000A3_000000A2_000000A1_000000A0.
  - miss_count=1; stall drops on the re-lookup hit.
- Miss with mem_ack gapped by 3 idle cycles between beats → mem_req and mem_addr held steady during the gaps, line assembled correctly, stall high throughout until the re-lookup.
- Reset asserted after beat 1 ack → next cycle mem_req=0, stall=0, state IDLE, no line_we pulse; a stray mem_ack afterwards causes no change.
- Back-to-back hits at 0x00, 0x04, 0x08 → one response per cycle with no stall.
- Preloaded miss_count near saturation: force 0xFFFE, then two misses → counts 0xFFFF and stays at 0xFFFF.
